// File: rtl/alu_iter_seq_if.sv
// Bundles the request/response and shared-ALU signals of alu_iter_seq.
//   start/op/a/b   : operation request, sampled by the sequencer in IDLE
//   busy/done      : sequencer status; done is a one-cycle pulse
//   result         : registered result, held until the next accepted start
//   alu_ctrl/n1/n2 : drive toward the shared ALU while busy
//   alu_out/flag   : shared ALU response
// master = requester plus shared ALU side, slave = the sequencer.
interface alu_iter_seq_if #(
    parameter int unsigned W = 32
) ();
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_n1;
    logic [W-1:0] alu_n2;
    logic [W-1:0] alu_out;
    logic         alu_flag;

    modport master (
        output start, op, a, b, alu_out, alu_flag,
        input  busy, done, result, alu_ctrl, alu_n1, alu_n2
    );

    modport slave (
        input  start, op, a, b, alu_out, alu_flag,
        output busy, done, result, alu_ctrl, alu_n1, alu_n2
    );
endinterface

// File: rtl/alu_iter_seq.sv
// Iterative MUL / DIVU / REMU sequencer driving a shared ALU, one ALU op per
// cycle for W cycles per instruction. Shifting, bit selection and result
// accumulation are local; every add/sub/compare is done by the external ALU.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_iter_seq_if slave modport (request, status, result, ALU drive)
module alu_iter_seq #(
    parameter int unsigned W = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_iter_seq_if.slave bus
);
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b1111;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    // Shifts left every RUN cycle: for MUL it is a << i, for DIV its MSB is a[W-1-i].
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   result_q, result_d;

    logic [3:0]     alu_ctrl;
    logic [W-1:0]   alu_n1;
    logic [W-1:0]   alu_n2;
    logic [W-1:0]   sh;
    logic           take;

    // Partial remainder shifted left with the next dividend bit appended.
    assign sh = {rem_q[W-2:0], a_q[W-1]};
    // A set MSB means the shifted value is at least 2^W > b, so subtract anyway;
    // the wrapped difference is then the exact remainder.
    assign take = rem_q[W-1] | bus.alu_flag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        alu_ctrl = AluAdd;
        alu_n1   = '0;
        alu_n2   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                a_d   = a_q << 1;
                if (!op_q[1]) begin
                    alu_ctrl = AluAdd;
                    alu_n1   = acc_q;
                    alu_n2   = b_q[cnt_q] ? a_q : '0;
                    acc_d    = bus.alu_out;
                end else begin
                    alu_ctrl = AluSub;
                    alu_n1   = sh;
                    alu_n2   = b_q;
                    rem_d    = take ? bus.alu_out : sh;
                    // Quotient bits arrive MSB first, so shift them in from the LSB.
                    quo_d    = {quo_q[W-2:0], take};
                end
                if (cnt_q == CntW'(W - 1)) begin
                    state_d  = StDone;
                    result_d = !op_q[1] ? acc_d : (op_q[0] ? rem_d : quo_d);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.result   = result_q;
    assign bus.alu_ctrl = alu_ctrl;
    assign bus.alu_n1   = alu_n1;
    assign bus.alu_n2   = alu_n2;
endmodule

// File: doc/alu_iter_seq.md
# alu_iter_seq

Iterative multiply/divide sequencer. It implements RV32M-style MUL, DIVU and REMU by driving a shared `alu` instance for one operation per cycle, W iterations per instruction. It sits beside the execute stage and owns the ALU's `ALUctrl`/`N1`/`N2` inputs while `busy` is high; the top level muxes those inputs back to the normal datapath otherwise. All shifting, bit selection and result accumulation live in this block; every add, subtract and compare goes through the ALU.

## Interface
- `W`, default 32: data width. Also the iteration count.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `op` input 2: operation select.
  - 00 = MUL, low W bits of the unsigned product.
  - 01 = MUL (reserved alias of 00).
  - 10 = DIVU.
  - 11 = REMU.
- `a` input W: multiplicand / dividend. Captured when `start` is accepted.
- `b` input W: multiplier / divisor. Captured when `start` is accepted.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse in DONE.
- `result` output W: registered result. Held until the next accepted `start`.
- `alu_ctrl` output 4: drives the shared ALU's `ALUctrl`.
- `alu_n1` output W: drives the ALU's `N1`.
- `alu_n2` output W: drives the ALU's `N2`.
- `alu_out` input W: the ALU's `out`.
- `alu_flag` input 1: the ALU's `flag`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start` is high. On that edge: capture `a`, `b`, `op`; clear `cnt`, `acc`, `rem`, `quo`.
  - RUN → DONE when `cnt` == W-1 and that iteration is committed.
  - DONE → IDLE unconditionally. `result` is written on the RUN→DONE edge.
  - `start` in RUN or DONE is ignored. It is not queued.
- ALU drive in IDLE and DONE: `alu_ctrl`=4'b0000, `alu_n1`=`alu_n2`=0.
- MUL, iteration i (i = `cnt`, 0..W-1):
  - `alu_ctrl`=4'b0000 (add), `alu_n1`=`acc`.
  - `alu_n2` = (`b_r`[i] ? `a_r` << i : 0). Implement as a shifted multiplicand register.
  - Commit: `acc` <= `alu_out`. Wrap-around mod 2^W is intended.
  - Final: `result` = `acc`.
- DIVU/REMU, restoring division, iteration i (bit index k = W-1-i):
  - `sh` = {`rem`[W-2:0], `a_r`[k]}.
  - `msb` = `rem`[W-1], the bit shifted out.
  - ALU drive: `alu_ctrl`=4'b1111 (sub, `flag` = carry = N1 ≥ N2 unsigned), `alu_n1`=`sh`, `alu_n2`=`b_r`.
  - `take` = `msb` | `alu_flag`.
  - If `take`: `rem` <= `alu_out`, `quo`[k] <= 1. Otherwise `rem` <= `sh`, `quo`[k] <= 0.
  - When `msb`=1 the true value exceeds `b_r`, and the wrapped W-bit difference is the correct remainder.
  - Final: `result` = `quo` for DIVU, `rem` for REMU.
- Divide by zero needs no special case. It yields DIVU = all-ones and REMU = `a`, which is the RISC-V-mandated result.
- Reset (`rst_n` low, at any time, including mid-operation):
  - The FSM goes to IDLE and the operation is aborted.
  - `busy`=0, `done`=0, `result`=0.
  - All internal registers are cleared.
  - ALU outputs return to the IDLE drive.

## Timing
- Cycle 0: `start`=1 is sampled at the rising edge.
- Cycles 1..W: RUN, one ALU op per cycle. `busy`=1.
- Cycle W+1: DONE. `done`=1, `busy`=1, `result` is valid.
- Cycle W+2: IDLE. `busy`=0. The earliest next `start` is sampled at the end of this cycle.
- Latency from the `start` edge to `done` is W+1 cycles; for W=32 that is 33. Throughput is one op per W+2 cycles.
- `alu_*` outputs are combinational from registered state only. The path from `alu_out`/`alu_flag` to the registers is the single-cycle critical path.
- `result` changes only on the RUN→DONE edge or on reset.

## Test plan
- MUL 7 × 6 → `done` at cycle 33, `result`=42, `busy` low at cycle 34; then MUL 0xFFFFFFFF × 0xFFFFFFFF → `result`=0x00000001.
- DIVU 100 / 7 → `result`=14; REMU 100 / 7 → `result`=2. Check `alu_ctrl`=4'b1111 throughout RUN.
- DIVU 0xFFFFFFFF / 0x80000001 → `result`=1; REMU → 0x7FFFFFFE. This exercises the `msb` path.
- DIVU 0x1234 / 0 → `result`=0xFFFFFFFF; REMU 0x1234 / 0 → `result`=0x00001234.
- Assert `start` with new operands at cycles 5 and 33 of a MUL → both ignored, the original result is returned, and no second `done` occurs.
- Drop `rst_n` at cycle 10 of a DIVU → `busy`, `done` and `result` go to 0 immediately (asynchronously). After release, a fresh DIVU 9 / 3 → `result`=3 at latency 33.
